// File: rtl/stream_fifo_flushable_pkg.sv
// Shared types and helpers for the flushable stream FIFO that sits ahead of
// each arbiter input.
package stream_fifo_flushable_pkg;

  localparam int unsigned DEFAULT_DEPTH = 4;

  // Occupancy mode; the FIFO has no other state beyond its pointers.
  typedef enum logic [1:0] {
    MODE_EMPTY   = 2'd0,
    MODE_PARTIAL = 2'd1,
    MODE_FULL    = 2'd2
  } fifo_mode_e;

  // Pointer increment with wrap at an arbitrary (non power-of-two) depth.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_flushable.sv
// Valid/ready FIFO with synchronous flush and optional fall-through, placed in
// front of one arbiter input so a stalled grant never blocks the source.
module stream_fifo_flushable
  import stream_fifo_flushable_pkg::*;
#(
  parameter type         DATA_T       = logic,
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter bit          FALL_THROUGH = 1'b0,
  localparam int unsigned ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  DATA_T           inp_data_i,
  input  logic            inp_valid_i,
  output logic            inp_ready_o,
  output DATA_T           oup_data_o,
  output logic            oup_valid_o,
  input  logic            oup_ready_i,
  output logic [ADDR_W:0] usage_o
);

  if (DEPTH == 0) begin : g_bad_depth
    $fatal(1, "stream_fifo_flushable: DEPTH must be >= 1");
  end

  // Handshakes: a transfer happens on a side exactly when valid and ready are
  // both high at the rising clock edge; neither side's valid may depend on the
  // other side's ready, and flush_i forces both ready and valid low.

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  DATA_T             mem [DEPTH];

  logic       empty, full;
  logic       push, pop, bypass;
  logic       do_write, do_read;
  fifo_mode_e mode;

  assign empty = (count == '0);
  assign full  = (count == (ADDR_W+1)'(DEPTH));

  always_comb begin
    mode = MODE_PARTIAL;
    if (empty)     mode = MODE_EMPTY;
    else if (full) mode = MODE_FULL;
  end

  assign inp_ready_o = !full && !flush_i;

  always_comb begin
    oup_valid_o = !empty && !flush_i;
    oup_data_o  = mem[rd_ptr];
    if (FALL_THROUGH && empty) begin
      oup_valid_o = inp_valid_i && !flush_i;
      oup_data_o  = inp_data_i;
    end
  end

  assign push = inp_valid_i && inp_ready_o;
  assign pop  = oup_valid_o && oup_ready_i;

  // A fall-through transfer consumes the item directly; storage is untouched.
  assign bypass   = FALL_THROUGH && empty && push && oup_ready_i;
  assign do_write = push && !bypass;
  assign do_read  = pop && !bypass;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= ADDR_W'(wrap_inc(32'(wr_ptr), DEPTH));
      if (do_read)  rd_ptr <= ADDR_W'(wrap_inc(32'(rd_ptr), DEPTH));
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; contents are only meaningful behind count.
  always_ff @(posedge clk_i) begin
    if (do_write) mem[wr_ptr] <= inp_data_i;
  end

  assign usage_o = count;

  a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && mode == MODE_FULL));

  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(do_read && mode == MODE_EMPTY));

  a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (oup_valid_o && !oup_ready_i && !flush_i) |=>
      (flush_i || (oup_valid_o && oup_data_o == $past(oup_data_o))));

  a_usage_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    usage_o <= (ADDR_W+1)'(DEPTH));

endmodule
